uart_rx_frame_check: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_vote.sv | 33 +++
 rtl/uart_rx_frame_check.sv | 136 +++++++++++++
 tb/tb_uart_rx_frame_check.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive frame engine.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Centre tick of a bit period.
  function automatic int mid_of(input int oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// Three-sample majority voter: captures the line at MID-1 and MID, combines
// them with the live line at MID+1.
module uart_rx_vote
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic                          CLK,
  input  logic                          sample_tick,
  input  logic [$clog2(OVERSAMPLE)-1:0] tick_pos,
  input  logic                          rx_in,
  output logic                          vote
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] POS_LO  = CNT_W'(mid_of(OVERSAMPLE) - 1);
  localparam logic [CNT_W-1:0] POS_MID = CNT_W'(mid_of(OVERSAMPLE));

  logic samp_lo_p0;
  logic samp_mid_p0;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge CLK) begin
    if (sample_tick && tick_pos == POS_LO)  samp_lo_p0  <= rx_in;
    if (sample_tick && tick_pos == POS_MID) samp_mid_p0 <= rx_in;
  end

  assign vote = majority3(samp_lo_p0, samp_mid_p0, rx_in);

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive frame engine: start validation, voted data bits, optional
// parity, STOP_BITS stop bits, registered word with per-frame error flags.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Sample_Tick,
  input  logic              Rx_In,
  input  logic              Par_En,
  input  logic              Par_Typ,
  output logic [DATA_W-1:0] Data,
  output logic              Data_Valid,
  output logic              Start_error,
  output logic              Parity_error,
  output logic              Stop_error,
  output logic              Busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] VOTE_TICK = CNT_W'(mid_of(OVERSAMPLE) + 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_e         state, state_nxt;
  logic [CNT_W-1:0]  tick_cnt, tick_pos;
  logic [IDX_W-1:0]  bit_idx;
  logic              stop_idx;
  logic              par_en_l, par_typ_l;
  logic              par_err_acc, stop_err_acc;
  logic [DATA_W-1:0] shift_p0;
  logic              vote;
  logic              at_vote, at_end;
  logic              frame_done, start_err_set;

  function automatic logic parity_fail(input logic [DATA_W-1:0] word,
                                       input logic pbit, input logic typ);
    logic want;
    want = (typ == PAR_EVEN) ? 1'b0 : 1'b1;
    return ((^word) ^ pbit) != want;
  endfunction

  // tick_cnt holds the position of the last consumed tick; the start tick is position 0.
  assign tick_pos = (tick_cnt == LAST_TICK) ? '0 : tick_cnt + CNT_W'(1);
  assign at_vote  = Sample_Tick && (tick_pos == VOTE_TICK);
  assign at_end   = Sample_Tick && (tick_pos == LAST_TICK);
  assign Busy     = (state != IDLE);

  uart_rx_vote #(.OVERSAMPLE(OVERSAMPLE)) u_vote (
    .CLK         (CLK),
    .sample_tick (Sample_Tick),
    .tick_pos    (tick_pos),
    .rx_in       (Rx_In),
    .vote        (vote)
  );

  always_comb begin
    state_nxt     = state;
    frame_done    = 1'b0;
    start_err_set = 1'b0;
    case (state)
      IDLE:   if (Sample_Tick && !Rx_In) state_nxt = START;
      START:  if (at_vote && vote) begin
                state_nxt     = IDLE;
                start_err_set = 1'b1;
              end else if (at_end) begin
                state_nxt = DATA;
              end
      DATA:   if (at_end && bit_idx == LAST_BIT) state_nxt = par_en_l ? PARITY : STOP;
      PARITY: if (at_end) state_nxt = STOP;
      STOP:   if (at_vote && stop_idx == LAST_STOP) begin
                state_nxt  = IDLE;
                frame_done = 1'b1;
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      par_en_l     <= 1'b0;
      par_typ_l    <= 1'b0;
      par_err_acc  <= 1'b0;
      stop_err_acc <= 1'b0;
      Data         <= '0;
      Data_Valid   <= 1'b0;
      Start_error  <= 1'b0;
      Parity_error <= 1'b0;
      Stop_error   <= 1'b0;
    end else begin
      state       <= state_nxt;
      Data_Valid  <= frame_done;
      Start_error <= start_err_set;
      if (Sample_Tick) begin
        if (state == IDLE) begin
          if (!Rx_In) begin
            tick_cnt     <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            par_en_l     <= Par_En;
            par_typ_l    <= Par_Typ;
            par_err_acc  <= 1'b0;
            stop_err_acc <= 1'b0;
          end
        end else begin
          tick_cnt <= tick_pos;
        end
      end
      if (state == DATA && at_end && bit_idx != LAST_BIT) bit_idx <= bit_idx + IDX_W'(1);
      if (state == PARITY && at_vote) par_err_acc <= parity_fail(shift_p0, vote, par_typ_l);
      if (state == STOP && at_vote) stop_err_acc <= stop_err_acc | ~vote;
      if (state == STOP && at_end) stop_idx <= stop_idx + 1'b1;
      if (frame_done) begin
        Data         <= shift_p0;
        Parity_error <= par_err_acc;
        Stop_error   <= stop_err_acc | ~vote;
      end
    end
  end

  // Data bits arrive LSB-first; after DATA_W shifts bit 0 sits at the bottom.
  always_ff @(posedge CLK) begin
    if (state == DATA && at_vote) shift_p0 <= {vote, shift_p0[DATA_W-1:1]};
  end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Scoreboard bench for uart_rx_frame_check: one 1-stop and one 2-stop instance.
module tb_uart_rx_frame_check;

  localparam int DATA_W = 8;
  localparam int OS     = 8;
  localparam int MID    = OS / 2;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
    int         tick;
    int         id;
  } res_t;

  logic CLK = 1'b0;
  logic RST, Sample_Tick, Rx_In, Par_En, Par_Typ, sel2;
  logic rx_a, rx_b;

  logic [DATA_W-1:0] a_data, b_data;
  logic a_dv, a_se, a_pe, a_ste, a_busy;
  logic b_dv, b_se, b_pe, b_ste, b_busy;

  res_t exp_q[$];
  res_t got_q[$];
  int   tick_count = 0;
  int   se_count   = 0;
  int   se_tick    = -1;
  bit   dv_multi   = 0;
  bit   overlap    = 0;
  logic a_dv_prev  = 1'b0;
  int   n_pass     = 0;
  int   n_total    = 0;

  assign rx_a = sel2 ? 1'b1 : Rx_In;
  assign rx_b = sel2 ? Rx_In : 1'b1;

  always #5 CLK = ~CLK;

  uart_rx_frame_check #(.DATA_W(DATA_W), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
    .CLK(CLK), .RST(RST), .Sample_Tick(Sample_Tick), .Rx_In(rx_a),
    .Par_En(Par_En), .Par_Typ(Par_Typ), .Data(a_data), .Data_Valid(a_dv),
    .Start_error(a_se), .Parity_error(a_pe), .Stop_error(a_ste), .Busy(a_busy)
  );

  uart_rx_frame_check #(.DATA_W(DATA_W), .OVERSAMPLE(OS), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .RST(RST), .Sample_Tick(Sample_Tick), .Rx_In(rx_b),
    .Par_En(Par_En), .Par_Typ(Par_Typ), .Data(b_data), .Data_Valid(b_dv),
    .Start_error(b_se), .Parity_error(b_pe), .Stop_error(b_ste), .Busy(b_busy)
  );

  always @(negedge CLK) begin
    if (a_dv) got_q.push_back('{a_data, a_pe, a_ste, tick_count, 1});
    if (b_dv) got_q.push_back('{b_data, b_pe, b_ste, tick_count, 2});
    if (a_se || b_se) begin
      se_count++;
      se_tick = tick_count;
    end
    if (a_dv && a_dv_prev) dv_multi = 1;
    if ((a_dv && a_se) || (b_dv && b_se)) overlap = 1;
    a_dv_prev = a_dv;
  end

  function automatic int latency(input int par, input int nstop);
    return (DATA_W + par + nstop) * OS + MID + 1;
  endfunction

  task automatic do_tick(input logic v);
    @(negedge CLK);
    Rx_In = v;
    Sample_Tick = 1'b1;
    tick_count++;
    @(negedge CLK);
    Sample_Tick = 1'b0;
    @(negedge CLK);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_present, input logic par_bit,
                            input logic stop1, input logic stop2, input int nstop,
                            input int last_ticks, input int g_bit, input int g_pos,
                            input int g_len);
    logic v;
    for (int k = 0; k < OS; k++) do_tick(1'b0);
    for (int b = 0; b < DATA_W; b++)
      for (int k = 0; k < OS; k++) begin
        v = d[b];
        if (b == g_bit && k >= g_pos && k < g_pos + g_len) v = ~v;
        do_tick(v);
      end
    if (par_present)
      for (int k = 0; k < OS; k++) do_tick(par_bit);
    for (int s = 0; s < nstop; s++) begin
      v = (s == 0) ? stop1 : stop2;
      for (int k = 0; k < ((s == nstop - 1) ? last_ticks : OS); k++) do_tick(v);
    end
  endtask

  task automatic get_result(output res_t r, output bit ok);
    int n = 0;
    r  = '{8'h00, 1'b0, 1'b0, -1, 0};
    ok = 0;
    while (got_q.size() == 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (got_q.size() != 0) begin
      r  = got_q.pop_front();
      ok = 1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Sample_Tick = 1'b0; Rx_In = 1'b1; Par_En = 1'b0; Par_Typ = 1'b0; sel2 = 1'b0;
    repeat (3) @(negedge CLK);
    n_total++;
    if ({a_data, a_dv, a_se, a_pe, a_ste, a_busy} !== 13'h0)
      $display("FAIL reset_a: got %h required 0", {a_data, a_dv, a_se, a_pe, a_ste, a_busy});
    else n_pass++;
    n_total++;
    if ({b_data, b_dv, b_se, b_pe, b_ste, b_busy} !== 13'h0)
      $display("FAIL reset_b: got %h required 0", {b_data, b_dv, b_se, b_pe, b_ste, b_busy});
    else n_pass++;
    RST = 1'b0;
    idle_ticks(3);
  endtask

  task automatic test_basic();
    res_t g, e;
    bit ok;
    exp_q.push_back('{8'hA5, 1'b0, 1'b0, tick_count + 1 + latency(0, 1), 1});
    send_frame(8'hA5, 0, 1'b0, 1'b1, 1'b1, 1, OS, -1, 0, 0);
    get_result(g, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok) $display("FAIL basic_dv: no Data_Valid seen, required one"); else n_pass++;
    n_total++; if (g.data !== e.data) $display("FAIL basic_data: got %h required %h", g.data, e.data); else n_pass++;
    n_total++; if ({g.perr, g.serr} !== 2'b00) $display("FAIL basic_err: got %b required 00", {g.perr, g.serr}); else n_pass++;
    n_total++; if (g.tick !== e.tick) $display("FAIL basic_latency: got tick %0d required %0d", g.tick, e.tick); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL basic_busy: got %b required 0", a_busy); else n_pass++;
    idle_ticks(4);
  endtask

  task automatic test_parity();
    res_t g, e;
    bit ok;
    Par_En = 1'b1; Par_Typ = 1'b0;
    exp_q.push_back('{8'h0F, 1'b0, 1'b0, tick_count + 1 + latency(1, 1), 1});
    send_frame(8'h0F, 1, 1'b0, 1'b1, 1'b1, 1, OS, -1, 0, 0);
    get_result(g, ok);
    e = exp_q.pop_front();
    n_total++; if (g.perr !== e.perr || !ok) $display("FAIL par_even_ok: got perr %b required %b", g.perr, e.perr); else n_pass++;
    n_total++; if (g.tick !== e.tick) $display("FAIL par_latency: got tick %0d required %0d", g.tick, e.tick); else n_pass++;
    idle_ticks(2);
    exp_q.push_back('{8'h0F, 1'b1, 1'b0, tick_count + 1 + latency(1, 1), 1});
    send_frame(8'h0F, 1, 1'b1, 1'b1, 1'b1, 1, OS, -1, 0, 0);
    get_result(g, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || g.perr !== e.perr) $display("FAIL par_even_bad: got perr %b required %b", g.perr, e.perr); else n_pass++;
    n_total++; if (g.data !== e.data) $display("FAIL par_data: got %h required %h", g.data, e.data); else n_pass++;
    idle_ticks(6);
    n_total++;
    if (a_data !== 8'h0F || a_pe !== 1'b1) $display("FAIL par_hold: got %h/%b required 0f/1", a_data, a_pe);
    else n_pass++;
    Par_Typ = 1'b1;
    exp_q.push_back('{8'h07, 1'b0, 1'b0, tick_count + 1 + latency(1, 1), 1});
    send_frame(8'h07, 1, 1'b0, 1'b1, 1'b1, 1, OS, -1, 0, 0);
    get_result(g, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || g.perr !== e.perr) $display("FAIL par_odd_ok: got perr %b required %b", g.perr, e.perr); else n_pass++;
    Par_En = 1'b0; Par_Typ = 1'b0;
    idle_ticks(2);
  endtask

  task automatic test_start_error();
    int se_before, start_idx;
    se_before = se_count;
    start_idx = tick_count + 1;
    do_tick(1'b0);
    n_total++; if (a_busy !== 1'b1) $display("FAIL start_busy_rise: got %b required 1", a_busy); else n_pass++;
    do_tick(1'b0);
    idle_ticks(10);
    n_total++; if (se_count !== se_before + 1) $display("FAIL start_err_count: got %0d required %0d", se_count - se_before, 1); else n_pass++;
    n_total++; if (se_tick !== start_idx + MID + 1) $display("FAIL start_err_tick: got %0d required %0d", se_tick, start_idx + MID + 1); else n_pass++;
    n_total++; if (got_q.size() !== 0) $display("FAIL start_no_dv: got %0d results required 0", got_q.size()); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL start_busy_fall: got %b required 0", a_busy); else n_pass++;
  endtask

  task automatic test_stop_error();
    res_t g, e;
    bit ok;
    exp_q.push_back('{8'h3C, 1'b0, 1'b1, tick_count + 1 + latency(0, 1), 1});
    send_frame(8'h3C, 0, 1'b0, 1'b0, 1'b1, 1, OS, -1, 0, 0);
    get_result(g, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || g.serr !== e.serr || g.data !== e.data) $display("FAIL stop1_err: got %h/%b required %h/%b", g.data, g.serr, e.data, e.serr); else n_pass++;
    idle_ticks(4);
    sel2 = 1'b1;
    exp_q.push_back('{8'hC3, 1'b0, 1'b0, tick_count + 1 + latency(0, 2), 2});
    send_frame(8'hC3, 0, 1'b0, 1'b1, 1'b1, 2, OS, -1, 0, 0);
    get_result(g, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || g.id !== 2 || g.serr !== 1'b0 || g.data !== e.data) $display("FAIL stop2_clean: got %h/%b id %0d required %h/0 id 2", g.data, g.serr, g.id, e.data); else n_pass++;
    n_total++; if (g.tick !== e.tick) $display("FAIL stop2_latency: got tick %0d required %0d", g.tick, e.tick); else n_pass++;
    idle_ticks(2);
    exp_q.push_back('{8'h96, 1'b0, 1'b1, tick_count + 1 + latency(0, 2), 2});
    send_frame(8'h96, 0, 1'b0, 1'b1, 1'b0, 2, OS, -1, 0, 0);
    get_result(g, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || g.serr !== e.serr) $display("FAIL stop2_second_err: got %b required %b", g.serr, e.serr); else n_pass++;
    n_total++; if (g.data !== e.data) $display("FAIL stop2_data: got %h required %h", g.data, e.data); else n_pass++;
    sel2 = 1'b0;
    idle_ticks(4);
  endtask

  task automatic test_glitch();
    res_t g, e;
    bit ok;
    exp_q.push_back('{8'h00, 1'b0, 1'b0, tick_count + 1 + latency(0, 1), 1});
    send_frame(8'h00, 0, 1'b0, 1'b1, 1'b1, 1, OS, 3, MID, 1);
    get_result(g, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || g.data !== e.data) $display("FAIL glitch_single: got %h required %h", g.data, e.data); else n_pass++;
    idle_ticks(2);
    exp_q.push_back('{8'h08, 1'b0, 1'b0, tick_count + 1 + latency(0, 1), 1});
    send_frame(8'h00, 0, 1'b0, 1'b1, 1'b1, 1, OS, 3, MID - 1, 2);
    get_result(g, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || g.data !== e.data) $display("FAIL glitch_double: got %h required %h", g.data, e.data); else n_pass++;
    idle_ticks(2);
  endtask

  task automatic test_back_to_back();
    res_t g, e;
    bit ok;
    logic [7:0] d2;
    int se_before;
    d2 = 8'hAA;
    se_before = se_count;
    exp_q.push_back('{8'h55, 1'b0, 1'b0, tick_count + 1 + latency(0, 1), 1});
    send_frame(8'h55, 0, 1'b0, 1'b1, 1'b1, 1, MID + 2, -1, 0, 0);
    for (int k = 0; k < OS; k++) do_tick(1'b0);
    get_result(g, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || g.data !== e.data) $display("FAIL b2b_first: got %h required %h", g.data, e.data); else n_pass++;
    n_total++; if (a_busy !== 1'b1) $display("FAIL b2b_second_start: got busy %b required 1", a_busy); else n_pass++;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < OS; k++) do_tick(d2[b]);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    n_total++; if (a_busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", a_busy); else n_pass++;
    n_total++;
    if ({a_data, a_dv, a_se, a_pe, a_ste} !== 12'h0)
      $display("FAIL rst_outputs: got %h required 0", {a_data, a_dv, a_se, a_pe, a_ste});
    else n_pass++;
    idle_ticks(2 * OS);
    n_total++; if (got_q.size() !== 0 || se_count !== se_before) $display("FAIL rst_no_pulse: got %0d results %0d start errors required 0", got_q.size(), se_count - se_before); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_start_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    n_total++; if (dv_multi !== 1'b0) $display("FAIL dv_width: got wide pulse %b required 0", dv_multi); else n_pass++;
    n_total++; if (overlap !== 1'b0) $display("FAIL dv_se_overlap: got %b required 0", overlap); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
